// File: rtl/cpu_trace_buffer_pkg.sv
// cpu_trace_buffer_pkg
//   Shared definitions for the CPU trace buffer: FSM state codes and the
//   helper that sizes one trace entry {stamp, state, mar}.
package cpu_trace_buffer_pkg;

  // Encodings are fixed so the codes line up with existing trace tooling.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARMED = 3'd1,
    ST_POST  = 3'd2,
    ST_DONE  = 3'd3,
    ST_READ  = 3'd4
  } trc_state_e;

  // Width of one stored entry: cycle stamp, control state, MAR value.
  function automatic int entry_w(input int cyc_w, input int state_w, input int data_w);
    return cyc_w + state_w + data_w;
  endfunction

endpackage

// File: rtl/cpu_trace_buffer_if.sv
// cpu_trace_buffer_if
//   Bundles the trace capture inputs, the read-out port and the status
//   outputs of cpu_trace_buffer.
//   master : drives arm/en/mode/cu_state/mar/trig_state/post_cnt/rd_req,
//            observes rd_valid/rd_data/rd_last/busy/done/count
//   slave  : the trace buffer itself (opposite directions)
interface cpu_trace_buffer_if #(
  parameter int STATE_W = 5,
  parameter int DATA_W  = 32,
  parameter int CYC_W   = 16,
  parameter int DEPTH   = 64
);
  localparam int AW = $clog2(DEPTH);
  localparam int EW = cpu_trace_buffer_pkg::entry_w(CYC_W, STATE_W, DATA_W);

  // capture side
  logic               arm;
  logic               en;
  logic               mode;
  logic [STATE_W-1:0] cu_state;
  logic [DATA_W-1:0]  mar;
  logic [STATE_W-1:0] trig_state;
  logic [AW-1:0]      post_cnt;
  // read side
  logic               rd_req;
  logic               rd_valid;
  logic [EW-1:0]      rd_data;
  logic               rd_last;
  // status
  logic               busy;
  logic               done;
  logic [AW:0]        count;

  modport master (
    output arm, en, mode, cu_state, mar, trig_state, post_cnt, rd_req,
    input  rd_valid, rd_data, rd_last, busy, done, count
  );

  modport slave (
    input  arm, en, mode, cu_state, mar, trig_state, post_cnt, rd_req,
    output rd_valid, rd_data, rd_last, busy, done, count
  );

endinterface

// File: rtl/cpu_trace_buffer_ram.sv
// cpu_trace_buffer_ram
//   Simple dual-port trace storage: one synchronous write port, one
//   synchronous read port with registered output. No reset on the array
//   or the read register; the owner qualifies the output with its own valid.
//   clk          : clock
//   we/waddr/wdata : write port
//   re/raddr     : read request, data appears on rdata after the edge
//   rdata        : registered read data
module cpu_trace_buffer_ram #(
  parameter int AW = 6,
  parameter int EW = 53
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [EW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [EW-1:0] rdata
);

  logic [EW-1:0] mem [0:(1<<AW)-1];

  // Writes happen only while capturing and reads only once frozen, so the
  // two ports never touch the same word in the same cycle.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/cpu_trace_buffer.sv
// cpu_trace_buffer
//   On-chip trace of the multicycle CPU control unit. Samples {stamp,
//   cu_state, mar} into a circular buffer while armed, stops a programmable
//   number of samples after a trigger state, then drains oldest-first.
//   clk    : rising-edge clock
//   reset  : asynchronous, active-low; clears FSM, pointers, counters, stamp
//   bus    : cpu_trace_buffer_if.slave (capture inputs, read port, status)
module cpu_trace_buffer
  import cpu_trace_buffer_pkg::*;
#(
  parameter int STATE_W = 5,
  parameter int DATA_W  = 32,
  parameter int CYC_W   = 16,
  parameter int DEPTH   = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  cpu_trace_buffer_if.slave    bus
);

  localparam int          AW   = $clog2(DEPTH);
  localparam int          EW   = entry_w(CYC_W, STATE_W, DATA_W);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE  = (AW+1)'(1);

  trc_state_e         st;
  logic [CYC_W-1:0]   stamp;
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [AW:0]        count;
  logic [AW-1:0]      post_l;     // post_cnt captured at arm
  logic [AW-1:0]      remaining;  // samples still to take after trigger
  logic [STATE_W-1:0] prev_state;
  logic               first;      // no sample stored since arm
  logic               rd_valid_q;
  logic               rd_last_q;
  logic [EW-1:0]      ram_q;

  logic capturing;
  logic changed;
  logic sample;
  logic hit;
  logic pop;

  assign capturing = (st == ST_ARMED) || (st == ST_POST);
  // First sample after arm is always kept in change-only mode, so the trace
  // never starts without a reference state.
  assign changed   = first || (bus.cu_state != prev_state);
  assign sample    = capturing && bus.en && (!bus.mode || changed);
  // Trigger only on samples that actually land in the buffer.
  assign hit       = sample && (bus.cu_state == bus.trig_state);
  assign pop       = ((st == ST_DONE) || (st == ST_READ)) && bus.rd_req && (count != '0);

  cpu_trace_buffer_ram #(
    .AW (AW),
    .EW (EW)
  ) u_ram (
    .clk   (clk),
    .we    (sample),
    .waddr (wr_ptr),
    .wdata ({stamp, bus.cu_state, bus.mar}),
    .re    (pop),
    .raddr (rd_ptr),
    .rdata (ram_q)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st         <= ST_IDLE;
      stamp      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      post_l     <= '0;
      remaining  <= '0;
      prev_state <= '0;
      first      <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
    end else begin
      stamp      <= stamp + 1'b1;
      rd_valid_q <= pop;
      rd_last_q  <= pop && (count == ONE);

      if (capturing && bus.en) prev_state <= bus.cu_state;

      // Circular write: once full, the oldest entry is dropped by moving
      // the read pointer along with the write pointer.
      if (sample) begin
        wr_ptr <= wr_ptr + 1'b1;
        first  <= 1'b0;
        if (count == FULL) rd_ptr <= rd_ptr + 1'b1;
        else               count  <= count + 1'b1;
      end

      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        count  <= count - 1'b1;
      end

      unique case (st)
        ST_IDLE: begin
          if (bus.arm) begin
            st     <= ST_ARMED;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            first  <= 1'b1;
            post_l <= bus.post_cnt;
          end
        end
        ST_ARMED: begin
          if (hit) begin
            if (post_l == '0) begin
              st <= ST_DONE;
            end else begin
              st        <= ST_POST;
              remaining <= post_l;
            end
          end
        end
        ST_POST: begin
          if (sample) begin
            remaining <= remaining - 1'b1;
            if (remaining == AW'(1)) st <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (pop) st <= (count == ONE) ? ST_IDLE : ST_READ;
        end
        ST_READ: begin
          if (pop && (count == ONE)) st <= ST_IDLE;
        end
        default: st <= ST_IDLE;
      endcase
    end
  end

  // RAM output is unreset; hold the bus at zero whenever it is not valid.
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_data  = rd_valid_q ? ram_q : '0;
  assign bus.rd_last  = rd_last_q;
  assign bus.busy     = capturing;
  assign bus.done     = (st == ST_DONE);
  assign bus.count    = count;

endmodule

// File: tb/tb_cpu_trace_buffer.sv
module tb_cpu_trace_buffer;

  localparam int STATE_W = 5;
  localparam int DATA_W  = 32;
  localparam int CYC_W   = 16;
  localparam int DEPTH   = 8;
  localparam int EW      = CYC_W + STATE_W + DATA_W;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  cpu_trace_buffer_if #(.STATE_W(STATE_W), .DATA_W(DATA_W), .CYC_W(CYC_W), .DEPTH(DEPTH)) bus ();

  cpu_trace_buffer #(.STATE_W(STATE_W), .DATA_W(DATA_W), .CYC_W(CYC_W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [STATE_W-1:0] f_st(input logic [EW-1:0] d);
    return d[DATA_W +: STATE_W];
  endfunction
  function automatic logic [CYC_W-1:0] f_stamp(input logic [EW-1:0] d);
    return d[DATA_W+STATE_W +: CYC_W];
  endfunction

  // ---------------- behavioural model ----------------
  typedef enum {M_IDLE, M_ARMED, M_POST, M_DONE, M_READ} mph_e;
  mph_e               ph = M_IDLE;
  logic [EW-1:0]      q[$];
  logic [CYC_W-1:0]   stamp_m = '0;
  logic [STATE_W-1:0] prev_m = '0;
  bit                 first_m = 0;
  int                 rem_m = 0;
  int                 postl_m = 0;
  bit                 ev = 0;
  bit                 el = 0;
  logic [EW-1:0]      ed = '0;

  always @(posedge clk) begin
    bit smp;
    if (!rst_n) begin
      ph = M_IDLE; q.delete(); stamp_m = '0; first_m = 0; ev = 0; el = 0;
    end else begin
      ev = 0; el = 0;
      case (ph)
        M_IDLE: if (bus.arm) begin
          ph = M_ARMED; q.delete(); first_m = 1; postl_m = int'(bus.post_cnt);
        end
        M_ARMED, M_POST: if (bus.en) begin
          smp = !bus.mode || first_m || (bus.cu_state != prev_m);
          prev_m = bus.cu_state;
          if (smp) begin
            q.push_back({stamp_m, bus.cu_state, bus.mar});
            if (q.size() > DEPTH) void'(q.pop_front());
            first_m = 0;
            if (ph == M_ARMED) begin
              if (bus.cu_state == bus.trig_state) begin
                if (postl_m == 0) ph = M_DONE;
                else begin ph = M_POST; rem_m = postl_m; end
              end
            end else begin
              rem_m--;
              if (rem_m == 0) ph = M_DONE;
            end
          end
        end
        M_DONE, M_READ: if (bus.rd_req && q.size() > 0) begin
          ev = 1; ed = q.pop_front(); el = (q.size() == 0);
          ph = el ? M_IDLE : M_READ;
        end
        default: ;
      endcase
      stamp_m = stamp_m + 1'b1;
    end
    #1;
    chk("busy", 64'(bus.busy), 64'(ph == M_ARMED || ph == M_POST));
    chk("done", 64'(bus.done), 64'(ph == M_DONE));
    chk("count", 64'(bus.count), 64'(q.size()));
    chk("rd_valid", 64'(bus.rd_valid), 64'(ev));
    if (ev) begin
      chk("rd_data", 64'(bus.rd_data), 64'(ed));
      chk("rd_last", 64'(bus.rd_last), 64'(el));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle_in();
    bus.arm = 0; bus.en = 0; bus.mode = 0; bus.rd_req = 0;
  endtask

  logic [EW-1:0]    d;
  logic [CYC_W-1:0] s_prev;
  logic [CYC_W-1:0] s_a;

  initial begin
    int s3[7];
    int e3[4];
    int g3[3];
    rst_n = 0;
    idle_in();
    bus.cu_state = '0; bus.mar = '0; bus.trig_state = '0; bus.post_cnt = '0;
    step(); step();
    chk("reset_busy", 64'(bus.busy), 0);
    chk("reset_done", 64'(bus.done), 0);
    chk("reset_count", 64'(bus.count), 0);
    chk("reset_rd_valid", 64'(bus.rd_valid), 0);
    rst_n = 1;

    // mid-run reset, then stamp restarts from 0 (also post_cnt=0 trigger)
    bus.arm = 1; bus.trig_state = 5'd31; bus.post_cnt = 3'd3; step();
    bus.arm = 0; bus.en = 1;
    for (int i = 0; i < 4; i++) begin bus.cu_state = 5'(i); bus.mar = $urandom; step(); end
    rst_n = 0; #1;
    chk("midreset_busy", 64'(bus.busy), 0);
    chk("midreset_count", 64'(bus.count), 0);
    chk("midreset_rd_valid", 64'(bus.rd_valid), 0);
    idle_in(); step(); step();
    rst_n = 1; bus.arm = 1; bus.post_cnt = '0; bus.trig_state = 5'd7; step();
    bus.arm = 0; bus.en = 1; bus.cu_state = 5'd7; bus.mar = 32'hCAFE_0001; step();
    chk("t4_done", 64'(bus.done), 1);
    chk("t4_count", 64'(bus.count), 1);
    bus.en = 0; bus.rd_req = 1; step();
    d = bus.rd_data;
    chk("t4_valid", 64'(bus.rd_valid), 1);
    chk("t4_last", 64'(bus.rd_last), 1);
    chk("t4_stamp", 64'(f_stamp(d)), 1);
    chk("t4_state", 64'(f_st(d)), 7);
    chk("t4_mar", 64'(d[DATA_W-1:0]), 64'h0000_0000_CAFE_0001);
    bus.rd_req = 0; step();
    chk("t4_idle", 64'({bus.busy, bus.done, bus.count}), 0);

    // mode0 wrap: states 0..11, trigger 9, two post samples
    bus.arm = 1; bus.mode = 0; bus.trig_state = 5'd9; bus.post_cnt = 3'd2; step();
    bus.arm = 0; bus.en = 1;
    for (int i = 0; i < 12; i++) begin bus.cu_state = 5'(i); bus.mar = $urandom; step(); end
    chk("t2_done", 64'(bus.done), 1);
    chk("t2_count", 64'(bus.count), 8);
    bus.en = 0;
    for (int i = 0; i < 8; i++) begin
      bus.rd_req = 1; step();
      d = bus.rd_data;
      chk("t2_state", 64'(f_st(d)), 64'(4 + i));
      if (i > 0) chk("t2_stamp_step", 64'(f_stamp(d) - s_prev), 1);
      chk("t2_last", 64'(bus.rd_last), 64'(i == 7));
      s_prev = f_stamp(d);
    end
    bus.rd_req = 0; step();
    chk("t2_idle", 64'({bus.busy, bus.done, bus.count}), 0);
    bus.rd_req = 1; step(); step();
    chk("t2_rd_after_last", 64'(bus.rd_valid), 0);
    bus.rd_req = 0;

    // mode1 change-only capture
    s3 = '{0, 0, 1, 1, 1, 2, 0};
    e3 = '{0, 1, 2, 0};
    g3 = '{2, 3, 1};
    bus.arm = 1; bus.mode = 1; bus.trig_state = 5'd2; bus.post_cnt = 3'd1; step();
    bus.arm = 0; bus.en = 1;
    for (int i = 0; i < 7; i++) begin bus.cu_state = 5'(s3[i]); bus.mar = $urandom; step(); end
    chk("t3_done", 64'(bus.done), 1);
    chk("t3_count", 64'(bus.count), 4);
    bus.en = 0;
    for (int i = 0; i < 4; i++) begin
      bus.rd_req = 1; step();
      d = bus.rd_data;
      chk("t3_state", 64'(f_st(d)), 64'(e3[i]));
      if (i > 0) chk("t3_stamp_gap", 64'(f_stamp(d) - s_prev), 64'(g3[i-1]));
      s_prev = f_stamp(d);
    end
    bus.rd_req = 0; bus.mode = 0; step();

    // en gap of 5 cycles in ARMED
    bus.arm = 1; bus.trig_state = 5'd31; bus.post_cnt = '0; step();
    bus.arm = 0; bus.en = 1; bus.cu_state = 5'd3; step();
    bus.en = 0;
    for (int i = 0; i < 5; i++) step();
    bus.en = 1; bus.cu_state = 5'd4; step();
    bus.cu_state = 5'd31; step();
    bus.en = 0;
    chk("t6_count", 64'(bus.count), 3);
    bus.rd_req = 1; step(); s_a = f_stamp(bus.rd_data);
    step(); d = bus.rd_data;
    chk("t6_gap", 64'(f_stamp(d) - s_a), 6);
    step();
    chk("t6_last", 64'(bus.rd_last), 1);
    bus.rd_req = 0; step();

    // reset during POST
    bus.arm = 1; bus.trig_state = 5'd1; bus.post_cnt = 3'd5; step();
    bus.arm = 0; bus.en = 1; bus.cu_state = 5'd1; step();
    bus.cu_state = 5'd2; step();
    chk("t5_busy_pre", 64'(bus.busy), 1);
    rst_n = 0; #1;
    chk("t5_busy", 64'(bus.busy), 0);
    chk("t5_count", 64'(bus.count), 0);
    idle_in(); step(); step();
    rst_n = 1; bus.rd_req = 1;
    for (int i = 0; i < 3; i++) begin step(); chk("t5_no_valid", 64'(bus.rd_valid), 0); end
    bus.rd_req = 0;

    // randomized traffic against the model
    for (int n = 0; n < 4000; n++) begin
      rst_n          = ($urandom_range(0, 399) != 0);
      bus.arm        = ($urandom_range(0, 9) == 0);
      bus.en         = ($urandom_range(0, 3) != 0);
      bus.mode       = 1'($urandom_range(0, 1));
      bus.cu_state   = 5'($urandom_range(0, 7));
      bus.mar        = $urandom;
      bus.trig_state = 5'($urandom_range(0, 7));
      bus.post_cnt   = 3'($urandom_range(0, 7));
      bus.rd_req     = 1'($urandom_range(0, 1));
      step();
    end
    rst_n = 1; idle_in(); step(); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
